// File: rtl/dpu_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpu_pio_pkg
// Purpose  : Shared PIO command encodings, arbiter state type and DPU memory
//            offsets used by the PIO arbiter and the DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
package dpu_pio_pkg;

    // PIO command type encodings understood by dpu_top
    localparam logic [2:0] CMD_WRITE_BYTE       = 3'd0;
    localparam logic [2:0] CMD_READ_BYTE        = 3'd2;
    localparam logic [2:0] CMD_WRITE_SCALE      = 3'd5;
    localparam logic [2:0] CMD_WRITE_LAYER_DESC = 3'd6;

    // Arbiter state machine encoding
    typedef enum logic [1:0] {
        S_ARB      = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2
    } arb_state_t;

    // DPU address-space offsets shared with the DMA engine
    localparam logic [23:0] FMAP_BASE_OFFSET = 24'h010000;
    localparam logic [23:0] BIAS_BASE_OFFSET = 24'h030000;

endpackage
`default_nettype wire

// File: rtl/dpu_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : dpu_rr_picker
// Purpose  : Combinational round-robin picker. Returns the first active
//            request found searching ptr+1, ptr+2, ... modulo NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
module dpu_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Walk the offsets in priority order; the first matching active request wins
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] && (i == ((int'(ptr) + off) % NUM_REQ))) begin
                    valid    = 1'b1;
                    idx      = IDX_W'(i);
                    grant[i] = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpu_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpu_pio_arbiter
// Purpose  : Shares the DPU PIO command/response port between NUM_REQ
//            requesters with per-command round-robin, optional grant lock,
//            read-response routing and a read-response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dpu_pio_arbiter
    import dpu_pio_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_BITS   = 24,
    parameter int RSP_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_cmd_valid,
    output logic [NUM_REQ-1:0]           req_cmd_ready,
    input  logic [NUM_REQ*3-1:0]         req_cmd_type,
    input  logic [NUM_REQ*ADDR_BITS-1:0] req_cmd_addr,
    input  logic [NUM_REQ*8-1:0]         req_cmd_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_rsp_valid,
    output logic [7:0]                   req_rsp_data,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd_type,
    output logic [ADDR_BITS-1:0]         cmd_addr,
    output logic [7:0]                   cmd_data,
    input  logic                         cmd_ready,
    input  logic                         rsp_valid,
    input  logic [7:0]                   rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    input  logic                         err_clr
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               TMO_W    = $clog2(RSP_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_owner;
    logic                 r_lock_hold;
    logic [TMO_W-1:0]     r_tmo_cnt;

    logic [NUM_REQ-1:0]   w_owner_oh;
    logic [NUM_REQ-1:0]   w_cand;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_accept;
    logic                 w_handoff;
    logic                 w_complete;
    logic                 w_tmo_fire;

    logic [2:0]           w_type [NUM_REQ];
    logic [ADDR_BITS-1:0] w_addr [NUM_REQ];
    logic [7:0]           w_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_type[gi] = req_cmd_type[gi*3 +: 3];
            assign w_addr[gi] = req_cmd_addr[gi*ADDR_BITS +: ADDR_BITS];
            assign w_data[gi] = req_cmd_data[gi*8 +: 8];
        end
    endgenerate

    // While the lock is held only the current owner may compete
    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_cand     = r_lock_hold ? (req_cmd_valid & w_owner_oh) : req_cmd_valid;

    dpu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (w_cand),
        .ptr   (r_ptr),
        .grant (w_pick_oh),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    assign grant_id = r_owner;
    assign busy     = (r_state != S_ARB);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_ARB;
        else        r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ARB:      if (w_accept)   w_state_next = S_ISSUE;
            S_ISSUE: begin
                if (w_complete)         w_state_next = S_ARB;
                else if (w_handoff)     w_state_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: if (w_complete) w_state_next = S_ARB;
            default:                    w_state_next = S_ARB;
        endcase
    end

    // Handshake outputs and response routing; rsp_valid only matters where a read is pending
    always_comb begin
        req_cmd_ready = '0;
        req_rsp_valid = '0;
        req_rsp_data  = '0;
        w_accept      = 1'b0;
        w_handoff     = 1'b0;
        w_complete    = 1'b0;
        w_tmo_fire    = 1'b0;
        case (r_state)
            S_ARB: begin
                if (w_pick_valid && rst_n) begin
                    req_cmd_ready = w_pick_oh;
                    w_accept      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    if (cmd_type == CMD_READ_BYTE) begin
                        if (rsp_valid) begin
                            req_rsp_valid = w_owner_oh;
                            req_rsp_data  = rsp_data;
                            w_complete    = 1'b1;
                        end else begin
                            w_handoff     = 1'b1;
                        end
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    req_rsp_valid = w_owner_oh;
                    req_rsp_data  = rsp_data;
                    w_complete    = 1'b1;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    req_rsp_valid = w_owner_oh;
                    req_rsp_data  = 8'hFF;
                    w_tmo_fire    = 1'b1;
                    w_complete    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Command capture, ownership, lock, timeout counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid   <= 1'b0;
            cmd_type    <= '0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            r_owner     <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_lock_hold <= 1'b0;
            r_tmo_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                cmd_valid <= 1'b1;
                cmd_type  <= w_type[w_pick_idx];
                cmd_addr  <= w_addr[w_pick_idx];
                cmd_data  <= w_data[w_pick_idx];
                r_owner   <= w_pick_idx;
            end
            // A read handed to the DPU must not be presented a second time
            if (w_handoff || w_complete) begin
                cmd_valid <= 1'b0;
            end
            if (w_complete) begin
                r_ptr       <= r_owner;
                r_lock_hold <= req_lock[r_owner];
            end
            // Saturating wait counter so it can never wrap back to a live value
            if (w_handoff) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT_RSP) && (r_tmo_cnt != '1)) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            if (w_tmo_fire)   timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dpu_pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpu_pio_arbiter
// Purpose  : Self-checking bench for dpu_pio_arbiter: arbitration vector
//            table, directed read/timeout/reset sequences and a randomized
//            run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpu_pio_arbiter;
    import dpu_pio_pkg::*;

    localparam int N   = 3;
    localparam int AW  = 24;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_cmd_valid, req_cmd_ready, req_lock, req_rsp_valid;
    logic [N*3-1:0]    req_cmd_type;
    logic [N*AW-1:0]   req_cmd_addr;
    logic [N*8-1:0]    req_cmd_data;
    logic [7:0]        req_rsp_data;
    logic              cmd_valid, cmd_ready, rsp_valid, busy, timeout_err, err_clr;
    logic [2:0]        cmd_type;
    logic [AW-1:0]     cmd_addr;
    logic [7:0]        cmd_data, rsp_data;
    logic [$clog2(N)-1:0] grant_id;

    dpu_pio_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
        .req_cmd_type(req_cmd_type), .req_cmd_addr(req_cmd_addr),
        .req_cmd_data(req_cmd_data), .req_lock(req_lock),
        .req_rsp_valid(req_rsp_valid), .req_rsp_data(req_rsp_data),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int r, input logic [2:0] t, input logic [AW-1:0] a, input logic [7:0] d);
        req_cmd_type[r*3 +: 3]   = t;
        req_cmd_addr[r*AW +: AW] = a;
        req_cmd_data[r*8 +: 8]   = d;
    endtask

    task automatic clear_inputs();
        req_cmd_valid = '0; req_lock = '0; req_cmd_type = '0;
        req_cmd_addr = '0; req_cmd_data = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-row stimulus fields, so the expected capture is known for any winner
    function automatic logic [2:0] row_type(input int r);
        return (r == 0) ? CMD_WRITE_BYTE : (r == 1) ? CMD_WRITE_SCALE : CMD_WRITE_LAYER_DESC;
    endfunction
    function automatic logic [AW-1:0] row_addr(input int i, input int r);
        return 24'h000010 + AW'(r) * 24'h100000 + AW'(i) * 24'h000100;
    endfunction
    function automatic logic [7:0] row_data(input int i, input int r);
        return 8'hA5 + 8'(i * 7) + 8'(r * 64);
    endfunction

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] lock;
        int           exp;   // expected winner, -1 for no grant
    } vec_t;

    vec_t tbl [20];

    // One arbitration row with cmd_ready held high (writes only)
    task automatic run_row(input int i);
        @(negedge clk);
        req_cmd_valid = tbl[i].valid;
        req_lock      = tbl[i].lock;
        for (int r = 0; r < N; r++) set_req(r, row_type(r), row_addr(i, r), row_data(i, r));
        #1;
        chk($sformatf("row%0d_busy_idle", i), busy, 0);
        if (tbl[i].exp < 0) begin
            chk($sformatf("row%0d_ready_none", i), req_cmd_ready, 0);
        end else begin
            chk($sformatf("row%0d_ready", i), req_cmd_ready, onehot(tbl[i].exp));
            @(negedge clk);
            #1;
            chk($sformatf("row%0d_cmd_valid", i), cmd_valid, 1);
            chk($sformatf("row%0d_grant_id", i), grant_id, tbl[i].exp);
            chk($sformatf("row%0d_cmd_type", i), cmd_type, row_type(tbl[i].exp));
            chk($sformatf("row%0d_cmd_addr", i), cmd_addr, row_addr(i, tbl[i].exp));
            chk($sformatf("row%0d_cmd_data", i), cmd_data, row_data(i, tbl[i].exp));
            chk($sformatf("row%0d_busy", i), busy, 1);
            chk($sformatf("row%0d_ready_issue", i), req_cmd_ready, 0);
        end
    endtask

    // Transaction-level reference model state
    bit           m_busy, m_hs, m_lock, m_err;
    int           m_owner, m_ptr, m_k, m_d;
    logic [2:0]   m_type;
    logic [AW-1:0] m_addr;
    logic [7:0]   m_data;

    initial begin
        logic [2:0] types [4];
        logic [N-1:0] exp_ready, exp_rv;
        logic [7:0]   exp_rd;
        bit done, tmo, found;
        int c;

        types[0] = CMD_WRITE_BYTE; types[1] = CMD_READ_BYTE;
        types[2] = CMD_WRITE_SCALE; types[3] = CMD_WRITE_LAYER_DESC;

        // Arbitration vectors starting from reset (pointer at NUM_REQ-1)
        tbl[0]  = '{3'b111, 3'b000, 0};
        tbl[1]  = '{3'b111, 3'b000, 1};
        tbl[2]  = '{3'b111, 3'b000, 2};
        tbl[3]  = '{3'b110, 3'b000, 1};
        tbl[4]  = '{3'b101, 3'b000, 2};
        tbl[5]  = '{3'b010, 3'b000, 1};
        tbl[6]  = '{3'b011, 3'b000, 0};
        tbl[7]  = '{3'b100, 3'b000, 2};
        tbl[8]  = '{3'b010, 3'b010, 1};   // lock burst starts
        tbl[9]  = '{3'b011, 3'b010, 1};
        tbl[10] = '{3'b011, 3'b000, 1};   // lock released on this completion
        tbl[11] = '{3'b011, 3'b000, 0};
        tbl[12] = '{3'b001, 3'b001, 0};   // owner locks
        tbl[13] = '{3'b110, 3'b000, -1};  // owner idle: others must wait
        tbl[14] = '{3'b111, 3'b000, 0};
        tbl[15] = '{3'b110, 3'b000, 1};
        tbl[16] = '{3'b011, 3'b000, 0};   // contention 0/1 alternates
        tbl[17] = '{3'b011, 3'b000, 1};
        tbl[18] = '{3'b011, 3'b000, 0};
        tbl[19] = '{3'b011, 3'b000, 1};

        // Reset values, with upstream requests and a stray response active
        rst_n = 1'b0;
        clear_inputs();
        req_cmd_valid = '1;
        cmd_ready = 1'b1;
        rsp_valid = 1'b1;
        #12;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_type", cmd_type, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_ready", req_cmd_ready, 0);
        chk("rst_rsp_valid", req_rsp_valid, 0);

        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) run_row(i);

        // Read routing with a stalled handshake and a late DPU answer
        do_reset();
        @(negedge clk);
        req_cmd_valid = 3'b010;
        set_req(1, CMD_READ_BYTE, 24'h024000, 8'h00);
        #1 chk("rd_ready", req_cmd_ready, 3'b010);
        @(negedge clk);
        req_cmd_valid = '0;
        set_req(1, CMD_WRITE_BYTE, 24'hFFFFFF, 8'h11);
        rsp_valid = 1'b1; rsp_data = 8'h77;
        for (int s = 0; s < 2; s++) begin
            #1;
            chk("rd_stall_valid", cmd_valid, 1);
            chk("rd_stall_addr", cmd_addr, 24'h024000);
            chk("rd_stall_type", cmd_type, CMD_READ_BYTE);
            chk("rd_stall_grant", grant_id, 1);
            chk("rd_stall_no_rsp", req_rsp_valid, 0);
            @(negedge clk);
        end
        cmd_ready = 1'b1; rsp_valid = 1'b0;
        #1 chk("rd_hs_valid", cmd_valid, 1);
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rsp_valid = (k == 5);
            rsp_data  = (k == 5) ? 8'h3C : 8'h00;
            #1;
            if (k < 5) begin
                chk("rd_wait_quiet", req_rsp_valid, 0);
            end else begin
                chk("rd_rsp_valid", req_rsp_valid, 3'b010);
                chk("rd_rsp_data", req_rsp_data, 8'h3C);
            end
            chk("rd_wait_busy", busy, 1);
            chk("rd_wait_cmd_valid", cmd_valid, 0);
            @(negedge clk);
        end
        rsp_valid = 1'b1; rsp_data = 8'h99;
        #1;
        chk("rd_stray_ignored", req_rsp_valid, 0);
        chk("rd_done_busy", busy, 0);
        @(negedge clk);
        rsp_valid = 1'b0;

        // Timeout: no DPU answer; err_clr in the timeout cycle loses
        do_reset();
        cmd_ready = 1'b1;
        @(negedge clk);
        req_cmd_valid = 3'b001;
        set_req(0, CMD_READ_BYTE, 24'h000123, 8'h00);
        #1 chk("to_ready", req_cmd_ready, 3'b001);
        @(negedge clk);
        req_cmd_valid = '0;
        #1 chk("to_hs_valid", cmd_valid, 1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            err_clr = (k == TMO);
            #1;
            if (k < TMO) begin
                chk("to_wait_quiet", req_rsp_valid, 0);
                chk("to_wait_err", timeout_err, 0);
            end else begin
                chk("to_rsp_valid", req_rsp_valid, 3'b001);
                chk("to_rsp_data", req_rsp_data, 8'hFF);
            end
        end
        @(negedge clk);
        err_clr = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h5A;
        #1;
        chk("to_err_set", timeout_err, 1);
        chk("to_stray_ignored", req_rsp_valid, 0);
        chk("to_done_busy", busy, 0);
        @(negedge clk);
        err_clr = 1'b0; rsp_valid = 1'b0;
        #1 chk("to_err_cleared", timeout_err, 0);

        // Asynchronous reset in the middle of a read
        do_reset();
        cmd_ready = 1'b1;
        @(negedge clk);
        req_cmd_valid = 3'b010;
        set_req(1, CMD_READ_BYTE, 24'h000777, 8'h00);
        #1 chk("mr_ready", req_cmd_ready, 3'b010);
        @(negedge clk);
        req_cmd_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("mr_busy_before", busy, 1);
        chk("mr_grant_before", grant_id, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_cmd_valid", cmd_valid, 0);
        chk("mr_cmd_addr", cmd_addr, 0);
        chk("mr_cmd_type", cmd_type, 0);
        chk("mr_grant_id", grant_id, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", req_rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1; rsp_valid = 1'b1; rsp_data = 8'h3C;
        #1;
        chk("mr_late_rsp_ignored", req_rsp_valid, 0);
        chk("mr_late_busy", busy, 0);
        @(negedge clk);
        rsp_valid = 1'b0;

        // Randomized traffic against the reference model
        do_reset();
        m_busy = 0; m_hs = 0; m_lock = 0; m_err = 0;
        m_owner = 0; m_ptr = N - 1; m_k = 0; m_d = 0;
        m_type = '0; m_addr = '0; m_data = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < N; r++) begin
                req_cmd_valid[r] = ($urandom_range(0, 99) < 40);
                req_lock[r]      = ($urandom_range(0, 99) < 30);
                set_req(r, types[$urandom_range(0, 3)], AW'($urandom), 8'($urandom));
            end
            err_clr   = ($urandom_range(0, 99) < 5);
            cmd_ready = ($urandom_range(0, 99) < 70);
            rsp_data  = 8'($urandom);
            rsp_valid = ($urandom_range(0, 99) < 20);
            // DPU stub: reply d cycles after the read handshake, or never for d > TMO
            if (m_busy && !m_hs && (m_type == CMD_READ_BYTE) && cmd_ready) begin
                m_d = $urandom_range(0, TMO + 4);
                rsp_valid = (m_d == 0);
            end else if (m_busy && m_hs) begin
                rsp_valid = ((m_k + 1) == m_d);
            end
            #1;
            chk("rnd_cmd_valid", cmd_valid, (m_busy && !m_hs));
            chk("rnd_busy", busy, m_busy);
            chk("rnd_grant_id", grant_id, m_owner);
            chk("rnd_timeout_err", timeout_err, m_err);
            if (m_busy && !m_hs) begin
                chk("rnd_cmd_type", cmd_type, m_type);
                chk("rnd_cmd_addr", cmd_addr, m_addr);
                chk("rnd_cmd_data", cmd_data, m_data);
            end
            exp_ready = '0; exp_rv = '0; exp_rd = '0; done = 0; tmo = 0; found = 0;
            if (!m_busy) begin
                for (int off = 1; off <= N; off++) begin
                    c = (m_ptr + off) % N;
                    if (!found && req_cmd_valid[c] && (!m_lock || c == m_owner)) begin
                        found = 1;
                        exp_ready = onehot(c);
                        m_busy = 1; m_hs = 0; m_owner = c;
                        m_type = req_cmd_type[c*3 +: 3];
                        m_addr = req_cmd_addr[c*AW +: AW];
                        m_data = req_cmd_data[c*8 +: 8];
                    end
                end
            end else if (!m_hs) begin
                if (cmd_ready) begin
                    if (m_type == CMD_READ_BYTE) begin
                        if (m_d == 0) begin
                            exp_rv = onehot(m_owner); exp_rd = rsp_data; done = 1;
                        end else begin
                            m_hs = 1; m_k = 0;
                        end
                    end else begin
                        done = 1;
                    end
                end
            end else begin
                m_k++;
                if (m_k == m_d) begin
                    exp_rv = onehot(m_owner); exp_rd = rsp_data; done = 1;
                end else if (m_k == TMO) begin
                    exp_rv = onehot(m_owner); exp_rd = 8'hFF; done = 1; tmo = 1;
                end
            end
            chk("rnd_ready", req_cmd_ready, exp_ready);
            chk("rnd_rsp_valid", req_rsp_valid, exp_rv);
            if (exp_rv != '0) chk("rnd_rsp_data", req_rsp_data, exp_rd);
            if (done) begin
                m_busy = 0; m_hs = 0; m_ptr = m_owner; m_lock = req_lock[m_owner];
            end
            if (tmo) m_err = 1;
            else if (err_clr) m_err = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpu_pio_arbiter.md
# dpu_pio_arbiter

Shares the single DPU PIO command/response port between NUM_REQ requesters: the AXI-DMA streaming engine, the host CSR bridge, and the layer sequencer. Round-robin arbitration is applied per command. A requester can lock the grant to keep a byte burst atomic. Read responses are routed back to the issuing requester, and a response timeout guarantees forward progress if the DPU never answers a read.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2–4); requester 0 is the DMA engine.
- ADDR_BITS, 24, PIO address width.
- RSP_TIMEOUT, 1024, maximum cycles to wait for a read response; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req_cmd_valid  in  NUM_REQ  per-requester command valid.
- req_cmd_ready  out  NUM_REQ  per-requester accept; combinational.
- req_cmd_type  in  NUM_REQ*3  flattened; requester i occupies bits [i*3 +: 3].
- req_cmd_addr  in  NUM_REQ*ADDR_BITS  flattened.
- req_cmd_data  in  NUM_REQ*8  flattened.
- req_lock  in  NUM_REQ  hold the grant after the current command completes.
- req_rsp_valid  out  NUM_REQ  one-cycle response pulse to the owner.
- req_rsp_data  out  8  response byte, broadcast to all requesters.
- cmd_valid, cmd_type[2:0], cmd_addr[ADDR_BITS-1:0], cmd_data[7:0]  out  registered command to dpu_top.
- cmd_ready  in  1  dpu_top accept.
- rsp_valid  in  1, rsp_data  in  8  dpu_top read response.
- grant_id  out  $clog2(NUM_REQ)  current/last owner.
- busy  out  1  high in any state other than S_ARB.
- timeout_err  out  1  sticky; set when a read response times out.
- err_clr  in  1  clears timeout_err.

## Operation
The block is a three-state FSM: S_ARB, S_ISSUE, S_WAIT_RSP.

S_ARB:
- Candidate set = req_cmd_valid; if lock_hold is set, the candidate set is only the owner.
- Select the first candidate searching ptr+1, ptr+2, … modulo NUM_REQ.
- req_cmd_ready[sel] = 1 in the same cycle; this is the transfer.
- Capture type/addr/data into the cmd_* registers; set owner = sel, grant_id = sel, cmd_valid = 1; go to S_ISSUE.
- No candidate: stay in S_ARB with all ready = 0.

S_ISSUE:
- Hold cmd_* stable until cmd_ready.
- On cmd_ready with a non-read type: the command is complete.
- On cmd_ready with cmd_type == CMD_READ_BYTE:
  - If rsp_valid is high in the same cycle, deliver the response and complete.
  - Otherwise go to S_WAIT_RSP with tmo_cnt = 0.

S_WAIT_RSP:
- On rsp_valid: req_rsp_valid[owner] = 1, req_rsp_data = rsp_data; complete.
- Otherwise tmo_cnt increments. When tmo_cnt == RSP_TIMEOUT-1: req_rsp_valid[owner] = 1, req_rsp_data = 8'hFF, set timeout_err; complete.

Completion actions:
- cmd_valid = 0, ptr = owner, lock_hold = req_lock[owner]; return to S_ARB.

Rules:
- rsp_valid outside S_WAIT_RSP, or outside the S_ISSUE/cmd_ready cycle of a read, is ignored.
- If err_clr and a timeout occur in the same cycle, the timeout wins.
- lock_hold with the owner's req_cmd_valid low: the arbiter waits in S_ARB. The lock is released once req_lock[owner] is low when the owner's next command completes.
- tmo_cnt is $clog2(RSP_TIMEOUT)+1 bits wide and saturates; it cannot wrap.
- Reset asserted mid-transaction aborts the transaction with no response delivered. Any late rsp_valid after reset is ignored.

## Timing
- Reset values:
  - cmd_valid 0, cmd_type 0, cmd_addr 0, cmd_data 0.
  - grant_id 0, ptr NUM_REQ-1 (requester 0 wins the first contest), busy 0, timeout_err 0, lock_hold 0.
  - req_cmd_ready 0 and req_rsp_valid 0 while rst_n is low.
- Latency: upstream accept in cycle N gives cmd_valid at N+1.
- Write throughput with cmd_ready tied high is one command every 2 cycles.
- Read response reaches the owner in the same cycle rsp_valid arrives.
- Timeout response fires exactly RSP_TIMEOUT cycles after entering S_WAIT_RSP.
- cmd_* must not change while cmd_valid && !cmd_ready.

## Structure
- dpu_pio_pkg holds:
  - CMD_WRITE_BYTE=0, CMD_READ_BYTE=2, CMD_WRITE_SCALE=5, CMD_WRITE_LAYER_DESC=6.
  - The arbiter state enum.
  - FMAP/BIAS offset constants, shared with the DMA engine.
- Sub-module dpu_rr_picker: combinational. Inputs are the request vector and ptr; outputs are the one-hot grant and the encoded index. Reused by future multi-port schedulers.

## Test plan
- Single write: req0 writes addr 0x000010 data 0xA5, cmd_ready high → cmd_valid rises 1 cycle after accept, with addr 0x000010 / data 0xA5 / type 0; busy returns low 2 cycles after accept.
- Contention: req0 and req1 both valid continuously with 4 writes each → grants alternate 0,1,0,1,…; no requester is granted twice in a row.
- Lock burst: req1 holds req_lock high for 3 writes while req0 is also valid → req1 gets 3 consecutive grants, then req0 is granted next.
- Read routing: req1 reads addr 0x24000, DPU returns 0x3C after 5 cycles → req_rsp_valid[1] pulses once with data 0x3C; req_rsp_valid[0] stays 0.
- Timeout: with RSP_TIMEOUT=16, req0 reads and the DPU never responds → at cycle 16 in S_WAIT_RSP, req_rsp_valid[0] pulses with 0xFF and timeout_err=1; err_clr clears it. A stray rsp_valid afterwards is ignored.
- Reset mid-read: drop rst_n during S_WAIT_RSP → all outputs take reset values asynchronously; a later rsp_valid produces no req_rsp_valid.
